tse_reg_init_seq: RTL and testbench

- Scripted register-write sequencer for the Ethernet TSE MAC control/status port.
- Walks a table of up to NUM_ENTRIES (address, data) pairs supplied by upstream configuration logic and issues each one as a bus write.
- Handles the MAC busy/wait handshake, bounds every transfer with a timeout, and reports done/error with the index of the failing entry.
- Sits directly between MAC-setup logic (MAC address, command_config, frame length values) and the MAC register port.

---
 rtl/tse_reg_init_seq.sv | 206 ++++++++++++++++++++
 tb/tb_tse_reg_init_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tse_reg_init_seq.sv
// tse_reg_init_seq: walks a table of (address, data) pairs and writes each one to the TSE MAC register port.
// Optional feature macro TSE_SEQ_VERIFY_EN adds a masked readback check after every write.
module tse_reg_init_seq #(
  parameter int NUM_ENTRIES    = 8,
  parameter int TIMEOUT_CYCLES = 1023,
  localparam int CW = $clog2(NUM_ENTRIES + 1),
  localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CW-1:0]             entry_count,
  input  logic [NUM_ENTRIES*8-1:0]  tbl_addr,
  input  logic [NUM_ENTRIES*32-1:0] tbl_data,
  input  logic [NUM_ENTRIES*32-1:0] tbl_mask,
  input  logic [31:0]               reg_data_out,
  input  logic                      reg_busy,
  output logic [31:0]               reg_data_in,
  output logic [7:0]                reg_addr,
  output logic                      reg_rd,
  output logic                      reg_wr,
  output logic                      seq_busy,
  output logic                      seq_done,
  output logic                      seq_error,
  output logic [IW-1:0]             err_index,
  output logic [1:0]                err_code
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_NEXT,
    S_DONE,
    S_ERR
`ifdef TSE_SEQ_VERIFY_EN
    , S_VERIFY
`endif
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_index;
  logic [TW-1:0] r_tmo;
  logic          r_wr;
  logic [7:0]    r_addr;
  logic [31:0]   r_wdata;
  logic          r_busy;
  logic          r_done;
  logic          r_error;
  logic [IW-1:0] r_err_index;
  logic [1:0]    r_err_code;

  logic [CW-1:0] w_count_clamped;
  logic [IW-1:0] w_nxt_index;
  logic [7:0]    w_nxt_addr;
  logic [31:0]   w_nxt_data;
  logic          w_last;
  logic          w_tmo_hit;

  // Counts above the table depth are clamped so the walk never leaves the table.
  assign w_count_clamped = (entry_count > CW'(NUM_ENTRIES)) ? CW'(NUM_ENTRIES) : entry_count;
  assign w_nxt_index     = r_index + IW'(1);
  assign w_nxt_addr      = tbl_addr[{w_nxt_index, 3'b000} +: 8];
  assign w_nxt_data      = tbl_data[{w_nxt_index, 5'b00000} +: 32];
  assign w_last          = (CW'(r_index) == (r_count - CW'(1)));
  assign w_tmo_hit       = (r_tmo == TW'(TIMEOUT_CYCLES - 1));

`ifdef TSE_SEQ_VERIFY_EN
  logic        r_rd;
  logic [31:0] w_cur_data;
  logic [31:0] w_cur_mask;
  logic        w_rb_ok;

  assign w_cur_data = tbl_data[{r_index, 5'b00000} +: 32];
  assign w_cur_mask = tbl_mask[{r_index, 5'b00000} +: 32];
  assign w_rb_ok    = (((reg_data_out ^ w_cur_data) & w_cur_mask) == 32'd0);
  assign reg_rd     = r_rd;
`else
  logic w_unused_inputs;

  assign w_unused_inputs = ^{tbl_mask, reg_data_out};
  assign reg_rd          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_index     <= '0;
      r_tmo       <= '0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_index <= '0;
      r_err_code  <= '0;
`ifdef TSE_SEQ_VERIFY_EN
      r_rd        <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_code  <= 2'd0;
            r_err_index <= '0;
            if (w_count_clamped == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_WRITE;
              r_count <= w_count_clamped;
              r_index <= '0;
              r_tmo   <= '0;
              r_wr    <= 1'b1;
              r_addr  <= tbl_addr[7:0];
              r_wdata <= tbl_data[31:0];
              r_busy  <= 1'b1;
            end
          end
        end

        // Completion beats timeout: a cycle with reg_busy low always finishes the write.
        S_WRITE: begin
          if (!reg_busy) begin
            r_wr  <= 1'b0;
            r_tmo <= '0;
`ifdef TSE_SEQ_VERIFY_EN
            r_state <= S_VERIFY;
            r_rd    <= 1'b1;
`else
            r_state <= S_NEXT;
`endif
          end else if (w_tmo_hit) begin
            r_wr        <= 1'b0;
            r_state     <= S_ERR;
            r_busy      <= 1'b0;
            r_error     <= 1'b1;
            r_err_code  <= 2'd1;
            r_err_index <= r_index;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end

`ifdef TSE_SEQ_VERIFY_EN
        S_VERIFY: begin
          if (!reg_busy) begin
            r_rd <= 1'b0;
            if (w_rb_ok) begin
              r_state <= S_NEXT;
            end else begin
              r_state     <= S_ERR;
              r_busy      <= 1'b0;
              r_error     <= 1'b1;
              r_err_code  <= 2'd2;
              r_err_index <= r_index;
            end
          end else if (w_tmo_hit) begin
            r_rd        <= 1'b0;
            r_state     <= S_ERR;
            r_busy      <= 1'b0;
            r_error     <= 1'b1;
            r_err_code  <= 2'd1;
            r_err_index <= r_index;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
`endif

        S_NEXT: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_WRITE;
            r_index <= w_nxt_index;
            r_tmo   <= '0;
            r_wr    <= 1'b1;
            r_addr  <= w_nxt_addr;
            r_wdata <= w_nxt_data;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign reg_wr      = r_wr;
  assign reg_addr    = r_addr;
  assign reg_data_in = r_wdata;
  assign seq_busy    = r_busy;
  assign seq_done    = r_done;
  assign seq_error   = r_error;
  assign err_index   = r_err_index;
  assign err_code    = r_err_code;

endmodule

// File: tb/tb_tse_reg_init_seq.sv
// tb_tse_reg_init_seq: directed bench with a write scoreboard and a busy-stall responder for tse_reg_init_seq.
module tb_tse_reg_init_seq;

  localparam int NE  = 8;
  localparam int TMO = 16;
`ifdef TSE_SEQ_VERIFY_EN
  localparam int CPE = 3;
`else
  localparam int CPE = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    entry_count = '0;
  logic [63:0]   tbl_addr = '0;
  logic [255:0]  tbl_data = '0;
  logic [255:0]  tbl_mask = '0;
  logic [31:0]   reg_data_out = '0;
  logic          reg_busy = 1'b0;
  logic [31:0]   reg_data_in;
  logic [7:0]    reg_addr;
  logic          reg_rd;
  logic          reg_wr;
  logic          seq_busy;
  logic          seq_done;
  logic          seq_error;
  logic [2:0]    err_index;
  logic [1:0]    err_code;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } xfer_t;

  xfer_t       expQ[$];
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  stallAddr = '0;
  int          stallLeft = 0;
  int          stallCount = 0;
  int          writeCount = 0;
  bit          prevDone = 1'b0;
  logic [31:0] lastWrData = '0;
  logic [31:0] rdXor = '0;

  tse_reg_init_seq #(.NUM_ENTRIES(NE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .entry_count(entry_count),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .tbl_mask(tbl_mask),
    .reg_data_out(reg_data_out), .reg_busy(reg_busy),
    .reg_data_in(reg_data_in), .reg_addr(reg_addr), .reg_rd(reg_rd), .reg_wr(reg_wr),
    .seq_busy(seq_busy), .seq_done(seq_done), .seq_error(seq_error),
    .err_index(err_index), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setEntry(input int i, input logic [7:0] a, input logic [31:0] d, input logic [31:0] m);
    tbl_addr[i*8 +: 8]  = a;
    tbl_data[i*32 +: 32] = d;
    tbl_mask[i*32 +: 32] = m;
  endtask

  // Queue the writes the sequencer should make, then pulse start for one cycle.
  task automatic applyStimulus(input int n);
    int eff;
    eff = (n > NE) ? NE : n;
    entry_count = 4'(n);
    for (int i = 0; i < eff; i++)
      expQ.push_back({tbl_addr[i*8 +: 8], tbl_data[i*32 +: 32]});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitFinish();
    int k;
    k = 0;
    while (!(seq_done || seq_error) && k < 300) begin
      @(negedge clk);
      k++;
    end
    checkOutput("finish_seen", seq_done || seq_error, 1);
  endtask

  task automatic checkLatency(input string tag, input int cycles);
    repeat (cycles - 1) @(negedge clk);
    checkOutput({tag, "_busy_before"}, {seq_busy, seq_done}, 2'b10);
    @(negedge clk);
    checkOutput({tag, "_done"}, {seq_busy, seq_done, seq_error}, 3'b010);
  endtask

  // Bus responder and scoreboard: decides reg_busy for the cycle, then checks the strobe.
  initial begin
    forever begin
      @(negedge clk);
      reg_busy = reg_wr && (reg_addr == stallAddr) && (stallLeft > 0);
      if (reg_busy) begin
        stallLeft--;
        stallCount++;
      end
`ifdef TSE_SEQ_VERIFY_EN
      if (reg_rd) reg_data_out = lastWrData ^ rdXor;
`endif
      if (reg_wr) begin
        checkOutput("wr_expected", expQ.size() != 0, 1);
        checkOutput("wr_gap", prevDone, 0);
        checkOutput("rd_wr_exclusive", reg_rd, 0);
        if (expQ.size() != 0) begin
          checkOutput("wr_addr", reg_addr, expQ[0].a);
          checkOutput("wr_data", reg_data_in, expQ[0].d);
          if (!reg_busy) begin
            void'(expQ.pop_front());
            writeCount++;
            lastWrData = reg_data_in;
          end
        end
        prevDone = !reg_busy;
      end else begin
        prevDone = 1'b0;
      end
    end
  end

  initial begin
    int wc;
    int k;
    setEntry(0, 8'h03, 32'h33221100, 32'h0);
    setEntry(1, 8'h04, 32'h00005544, 32'h0);
    setEntry(2, 8'h02, 32'h0000003B, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs",
                {reg_wr, reg_rd, seq_busy, seq_done, seq_error, err_code, err_index, reg_addr}, '0);
    checkOutput("reset_wdata", reg_data_in, 0);
    rst = 1'b0;

    // Three entries, no stalls.
    applyStimulus(3);
    checkLatency("t1", 3 * CPE);
    checkOutput("t1_writes", writeCount, 3);
    checkOutput("t1_err", {seq_error, err_code}, 0);

    // Entry 1 stalls for four cycles.
    stallAddr = 8'h04; stallLeft = 4; stallCount = 0;
    applyStimulus(3);
    checkLatency("t2", 3 * CPE + 4);
    checkOutput("t2_stalls", stallCount, 4);
    checkOutput("t2_writes", writeCount, 6);

    // Entry 2 stuck busy until the timeout fires.
    stallAddr = 8'h02; stallLeft = 1000000; stallCount = 0;
    applyStimulus(3);
    waitFinish();
    checkOutput("t3_error", {seq_error, seq_done, seq_busy}, 3'b100);
    checkOutput("t3_code", err_code, 1);
    checkOutput("t3_index", err_index, 2);
    checkOutput("t3_stalls", stallCount, TMO);
    checkOutput("t3_strobe_low", reg_wr, 0);
    checkOutput("t3_pending", expQ.size(), 1);
    expQ.delete();
    stallLeft = 0;
    applyStimulus(3);
    waitFinish();
    checkOutput("t3_recover", {seq_done, seq_error, err_code}, 4'b1000);

    // Empty table, then an over-range count.
    wc = writeCount;
    applyStimulus(0);
    checkOutput("t4_empty_done", {seq_done, seq_busy, seq_error, reg_wr}, 4'b1000);
    repeat (3) @(negedge clk);
    checkOutput("t4_empty_nowrites", writeCount, wc);
    for (int i = 0; i < NE; i++)
      setEntry(i, 8'(8'h10 + i), 32'hA5000000 + 32'(i * 7), 32'h0);
    applyStimulus(15);
    waitFinish();
    checkOutput("t4_clamp_writes", writeCount, wc + NE);
    checkOutput("t4_clamp_done", {seq_done, seq_error}, 2'b10);

    // Reset while a write is stalled.
    stallAddr = 8'h11; stallLeft = 1000000; stallCount = 0;
    applyStimulus(3);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!(stallCount > 0 && reg_wr) && k < 100);
    checkOutput("t5_stalled", stallCount > 0 && reg_wr, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t5_rst_outputs",
                {reg_wr, reg_rd, seq_busy, seq_done, seq_error, err_code, err_index, reg_addr}, '0);
    rst = 1'b0;
    stallLeft = 0;
    expQ.delete();
    wc = writeCount;
    applyStimulus(3);
    checkLatency("t5", 3 * CPE);
    checkOutput("t5_writes", writeCount, wc + 3);

`ifdef TSE_SEQ_VERIFY_EN
    // Readback with bit 8 flipped: full mask fails, mask without bit 8 passes.
    setEntry(0, 8'h03, 32'h33221100, 32'hFFFFFFFF);
    rdXor = 32'h00000100;
    applyStimulus(1);
    waitFinish();
    checkOutput("t6_mismatch", {seq_error, err_code, err_index}, {1'b1, 2'd2, 3'd0});
    setEntry(0, 8'h03, 32'h33221100, 32'hFFFFFEFF);
    applyStimulus(1);
    waitFinish();
    checkOutput("t6_masked_pass", {seq_done, seq_error, err_code}, 4'b1000);
    rdXor = '0;
`endif

    checkOutput("queue_empty", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
